// File: rtl/regfile_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter_if
//  Brief    : Writeback request bus (ex + mem requesters) and the register
//             file write port driven by the arbiter.
//  Revision : 1.0  initial release
// ============================================================================
interface regfile_wb_arbiter_if #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  ex_valid;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic [XLEN-1:0]       ex_data;
    logic                  ex_ready;

    logic                  mem_valid;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic [XLEN-1:0]       mem_data;
    logic                  mem_ready;

    logic [REG_ADDR_W-1:0] write_addr_rd;
    logic [XLEN-1:0]       write_data_rd;
    logic                  we;

    // Requester side: pipeline writeback stages plus the register file sink
    modport master (
        output ex_valid, ex_rd, ex_data,
        input  ex_ready,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        input  write_addr_rd, write_data_rd, we
    );

    // Arbiter side
    modport slave (
        input  ex_valid, ex_rd, ex_data,
        output ex_ready,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        output write_addr_rd, write_data_rd, we
    );
endinterface
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_wb_arbiter
//  Brief    : Shares the single register file write port between the ex and
//             mem writeback requesters. mem (older) wins by default; ex is
//             boosted after MAX_WAIT consecutive losses.
//  Revision : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5,
    parameter int MAX_WAIT   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_wb_arbiter_if.slave    bus
);

    localparam int                c_cnt_w   = $clog2(MAX_WAIT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(MAX_WAIT);

    typedef enum logic [0:0] {
        ST_NORMAL = 1'b0,
        ST_BOOST  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [c_cnt_w-1:0]    r_starve_cnt;
    logic [REG_ADDR_W-1:0] r_write_addr;
    logic [XLEN-1:0]       r_write_data;
    logic                  r_we;

    logic w_boost;
    logic w_same_rd;
    logic w_ex_ready;
    logic w_mem_ready;
    logic w_ex_xfer;
    logic w_mem_xfer;

    // State register for the boost FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_NORMAL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Grant selection and next-state logic. Boost takes effect as soon as the
    // registered counter saturates, so ex wins the cycle after its last loss.
    always_comb begin
        w_ex_ready  = 1'b0;
        w_mem_ready = 1'b0;
        w_state_nxt = r_state;

        w_same_rd = (bus.ex_rd == bus.mem_rd) && (bus.ex_rd != '0);
        w_boost   = (r_state == ST_BOOST) || (r_starve_cnt == c_cnt_max);

        if (rst) begin
            w_ex_ready  = 1'b0;
            w_mem_ready = 1'b0;
        end else if (bus.ex_valid && bus.mem_valid) begin
            // A same-rd pair must retire in program order, so mem goes first
            w_ex_ready  = w_boost && !w_same_rd;
            w_mem_ready = !w_ex_ready;
        end else begin
            w_ex_ready  = bus.ex_valid;
            w_mem_ready = bus.mem_valid;
        end

        w_ex_xfer  = bus.ex_valid  && w_ex_ready;
        w_mem_xfer = bus.mem_valid && w_mem_ready;

        if (w_boost && !w_ex_xfer) begin
            w_state_nxt = ST_BOOST;
        end else begin
            w_state_nxt = ST_NORMAL;
        end
    end

    // Starvation counter: saturating count of consecutive ex losses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve_cnt <= '0;
        end else if (w_ex_xfer) begin
            r_starve_cnt <= '0;
        end else if (bus.ex_valid && !w_ex_ready && (r_starve_cnt != c_cnt_max)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end

    // Registered write port; x0 writes are accepted but never enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we         <= 1'b0;
            r_write_addr <= '0;
            r_write_data <= '0;
        end else if (w_mem_xfer) begin
            r_we         <= (bus.mem_rd != '0);
            r_write_addr <= bus.mem_rd;
            r_write_data <= bus.mem_data;
        end else if (w_ex_xfer) begin
            r_we         <= (bus.ex_rd != '0);
            r_write_addr <= bus.ex_rd;
            r_write_data <= bus.ex_data;
        end else begin
            r_we         <= 1'b0;
        end
    end

    assign bus.ex_ready      = w_ex_ready;
    assign bus.mem_ready     = w_mem_ready;
    assign bus.we            = r_we;
    assign bus.write_addr_rd = r_write_addr;
    assign bus.write_data_rd = r_write_data;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_regfile_wb_arbiter
//  Brief    : Self-checking bench for regfile_wb_arbiter. A reference model
//             predicts grants and pushes the expected write-port state into a
//             queue; it is popped and compared one cycle later.
//  Revision : 1.0  initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int MAX_WAIT   = 4;

    typedef struct {
        logic                  we;
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } exp_t;

    logic clk;
    logic rst;

    regfile_wb_arbiter_if #(.XLEN(XLEN), .REG_ADDR_W(REG_ADDR_W)) bus ();

    regfile_wb_arbiter #(
        .XLEN       (XLEN),
        .REG_ADDR_W (REG_ADDR_W),
        .MAX_WAIT   (MAX_WAIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    exp_t q_exp[$];

    // Reference model state
    int                    m_losses = 0;
    logic [REG_ADDR_W-1:0] m_addr   = '0;
    logic [XLEN-1:0]       m_data   = '0;

    // Readies sampled mid-cycle, for directed checks
    logic s_ex_ready;
    logic s_mem_ready;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic ev, input logic [REG_ADDR_W-1:0] erd, input logic [XLEN-1:0] ed,
                         input logic mv, input logic [REG_ADDR_W-1:0] mrd, input logic [XLEN-1:0] md);
        bus.ex_valid  = ev;
        bus.ex_rd     = erd;
        bus.ex_data   = ed;
        bus.mem_valid = mv;
        bus.mem_rd    = mrd;
        bus.mem_data  = md;
    endtask

    // One clock: predict and check readies, push expected port, clock, pop and compare
    task automatic cycle(input string tag);
        logic p_ex, p_mem, boost, same;
        exp_t e;
        exp_t g;
        #3;
        boost = (m_losses >= MAX_WAIT);
        same  = (bus.ex_rd == bus.mem_rd) && (bus.ex_rd != 0);
        if (rst) begin
            p_ex = 1'b0; p_mem = 1'b0;
        end else if (bus.ex_valid && bus.mem_valid) begin
            p_ex  = boost && !same;
            p_mem = !p_ex;
        end else begin
            p_ex  = bus.ex_valid;
            p_mem = bus.mem_valid;
        end
        s_ex_ready  = bus.ex_ready;
        s_mem_ready = bus.mem_ready;
        chk({tag, "_ex_ready"},  {63'd0, bus.ex_ready},  {63'd0, p_ex});
        chk({tag, "_mem_ready"}, {63'd0, bus.mem_ready}, {63'd0, p_mem});

        if (rst) begin
            m_losses = 0; m_addr = '0; m_data = '0;
            e.we = 1'b0;
        end else if (p_mem && bus.mem_valid) begin
            m_addr = bus.mem_rd; m_data = bus.mem_data;
            e.we = (bus.mem_rd != 0);
            if (bus.ex_valid && m_losses < MAX_WAIT) m_losses++;
        end else if (p_ex && bus.ex_valid) begin
            m_addr = bus.ex_rd; m_data = bus.ex_data;
            e.we = (bus.ex_rd != 0);
            m_losses = 0;
        end else begin
            e.we = 1'b0;
        end
        e.addr = m_addr;
        e.data = m_data;
        q_exp.push_back(e);

        @(posedge clk);
        #1;
        if (q_exp.size() == 0) begin
            chk({tag, "_queue_empty"}, 64'd1, 64'd0);
        end else begin
            g = q_exp.pop_front();
            chk({tag, "_we"},   {63'd0, bus.we},            {63'd0, g.we});
            chk({tag, "_addr"}, 64'(bus.write_addr_rd),     64'(g.addr));
            chk({tag, "_data"}, 64'(bus.write_data_rd),     64'(g.data));
        end
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22);

        // Reset with both requesters valid
        for (int i = 0; i < 2; i++) begin
            cycle("reset");
            chk("reset_no_ex_grant",  {63'd0, s_ex_ready},  64'd0);
            chk("reset_no_mem_grant", {63'd0, s_mem_ready}, 64'd0);
        end
        rst = 1'b0;
        chk("reset_we",   {63'd0, bus.we},        64'd0);
        chk("reset_addr", 64'(bus.write_addr_rd), 64'd0);
        chk("reset_data", 64'(bus.write_data_rd), 64'd0);

        // Single ex write
        drive(1'b1, 5'd1, 32'd7, 1'b0, 5'd0, 32'd0);
        cycle("ex_single");
        chk("ex_single_grant", {63'd0, s_ex_ready}, 64'd1);

        // Conflict: mem first, ex next
        drive(1'b1, 5'd3, 32'hB, 1'b1, 5'd2, 32'hA);
        cycle("conflict_mem");
        chk("conflict_mem_grant", {63'd0, s_mem_ready}, 64'd1);
        drive(1'b1, 5'd3, 32'hB, 1'b0, 5'd0, 32'd0);
        cycle("conflict_ex");
        chk("conflict_ex_grant", {63'd0, s_ex_ready}, 64'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cycle("conflict_idle");
        chk("conflict_ex_addr", 64'(bus.write_addr_rd), 64'd3);

        // Starvation: ex loses MAX_WAIT cycles, wins the next one
        for (int i = 0; i <= MAX_WAIT; i++) begin
            drive(1'b1, 5'd5, 32'h55, 1'b1, 5'(8 + i), 32'(32'h80 + i));
            cycle("starve");
            chk("starve_ex_grant", {63'd0, s_ex_ready}, (i == MAX_WAIT) ? 64'd1 : 64'd0);
        end
        chk("starve_port_addr", 64'(bus.write_addr_rd), 64'd5);
        // Counter cleared: a fresh conflict goes back to mem
        drive(1'b1, 5'd13, 32'h13, 1'b1, 5'(8 + MAX_WAIT), 32'(32'h80 + MAX_WAIT));
        cycle("post_boost");
        chk("post_boost_mem_grant", {63'd0, s_mem_ready}, 64'd1);
        drive(1'b1, 5'd13, 32'h13, 1'b0, 5'd0, 32'd0);
        cycle("post_boost_ex");

        // Same-rd conflict under boost keeps mem first
        for (int i = 0; i < MAX_WAIT; i++) begin
            drive(1'b1, 5'd6, 32'h60, 1'b1, 5'(16 + i), 32'(i));
            cycle("boost_reach");
        end
        drive(1'b1, 5'd6, 32'h60, 1'b1, 5'd6, 32'hA6);
        cycle("same_rd_mem");
        chk("same_rd_mem_grant", {63'd0, s_mem_ready}, 64'd1);
        chk("same_rd_first_data", 64'(bus.write_data_rd), 64'hA6);
        drive(1'b1, 5'd6, 32'h60, 1'b1, 5'd7, 32'hA7);
        cycle("same_rd_ex");
        chk("same_rd_ex_grant", {63'd0, s_ex_ready}, 64'd1);
        chk("same_rd_second_data", 64'(bus.write_data_rd), 64'h60);
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hA7);
        cycle("boost_mem_alone");
        chk("boost_mem_alone_grant", {63'd0, s_mem_ready}, 64'd1);

        // x0 write: accepted, no enable
        drive(1'b1, 5'd0, 32'hFF, 1'b0, 5'd0, 32'd0);
        cycle("x0");
        chk("x0_grant", {63'd0, s_ex_ready}, 64'd1);
        chk("x0_we",    {63'd0, bus.we},     64'd0);

        // Mid-operation reset while mem is pending
        drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99);
        rst = 1'b1;
        cycle("midrst");
        chk("midrst_no_grant", {63'd0, s_mem_ready}, 64'd0);
        rst = 1'b0;
        cycle("midrst_retry");
        chk("midrst_retry_grant", {63'd0, s_mem_ready}, 64'd1);
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        cycle("final_idle");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (write_addr_rd / write_data_rd / we) between two writeback requesters: ex (ALU results) and mem (load results).
- Uses valid/ready handshakes and fixed priority to mem, the older instruction.
- A starvation counter eventually forces a grant to ex.
- Sits between the pipeline writeback stages and the register file.

Parameters:
- XLEN, 32, data width.
- REG_ADDR_W, 5, register address width.
- MAX_WAIT, 4, consecutive ex losses before ex is boosted; legal range >=1.

Ports:
- clk  in  1  clock; all state updates on its rising edge.
- rst  in  1  synchronous reset, active-high.
- ex_valid  in  1  ex request.
- ex_rd  in  REG_ADDR_W  ex destination register.
- ex_data  in  XLEN  ex write data.
- ex_ready  out  1  ex request accepted this cycle.
- mem_valid  in  1  mem request.
- mem_rd  in  REG_ADDR_W  mem destination register.
- mem_data  in  XLEN  mem write data.
- mem_ready  out  1  mem request accepted this cycle.
- write_addr_rd  out  REG_ADDR_W  register file write address (registered).
- write_data_rd  out  XLEN  register file write data (registered).
- we  out  1  register file write enable (registered).

Behaviour:
- Transfer: occurs when valid && ready. The requester holds valid, rd and data stable until ready.
- ready timing: ex_ready and mem_ready are combinational from the valids, rd fields, boost state and rst. At most one ready is high per cycle.
- Write-port latency: 1 cycle. On a transfer in cycle N, in cycle N+1 write_addr_rd = rd, write_data_rd = data, and we = (rd != 0).
- Idle cycles: with no transfer in cycle N, we = 0 in cycle N+1. write_addr_rd and write_data_rd hold their last values.
- x0 writes: rd == 0 is accepted normally (ready = 1) but produces we = 0. It still counts as an ex transfer for the starvation counter.
- Grant with only one valid: that requester gets ready = 1.
- Grant with both valid, NORMAL state: mem is granted.
- Grant with both valid, BOOST state: ex is granted, except when ex_rd == mem_rd && ex_rd != 0. In that case mem is granted to preserve write order.
- starve_cnt:
  - width clog2(MAX_WAIT+1).
  - Increments when ex_valid && !ex_ready, saturating at MAX_WAIT.
  - Clears on any ex transfer.
- State machine, two states:
  - NORMAL -> BOOST when starve_cnt == MAX_WAIT. This is evaluated on the registered counter, so ex is granted on the cycle after the MAX_WAIT-th loss.
  - BOOST -> NORMAL on the cycle after an ex transfer, when the counter clears.
  - BOOST persists while a same-rd conflict keeps mem granted.
- Reset: while rst = 1:
  - ex_ready = mem_ready = 0, so no transfer occurs.
  - Next cycle: we = 0, write_addr_rd = 0, write_data_rd = 0, starve_cnt = 0, state = NORMAL.
  - A request in flight when rst is asserted is not accepted. The requester re-presents it after reset deasserts.
- Back-to-back transfers: one per cycle, no bubble required between them.
- Boundaries:
  - ex_valid dropping while starving is illegal per the handshake rule. If it happens, starve_cnt holds its value.
  - mem_valid alone in BOOST is granted immediately; boost never idles the port.

Test Plan:
- Reset: hold rst 2 cycles with both valids high -> ex_ready = mem_ready = 0 throughout; cycle after, we = 0, write_addr_rd = 0, write_data_rd = 0.
- Single ex write: ex_valid = 1, ex_rd = 1, ex_data = 7 -> ex_ready = 1 same cycle; next cycle we = 1, write_addr_rd = 1, write_data_rd = 7.
- Conflict: both valid, mem_rd = 2 / 0xA, ex_rd = 3 / 0xB -> mem first (we = 1, addr 2, data 0xA), then ex (addr 3, data 0xB) on the following cycle.
- Starvation, MAX_WAIT = 4: mem_valid held high with distinct rd each cycle, ex_valid high with ex_rd = 5 -> ex loses 4 cycles, is granted on cycle 5, port shows addr 5 on cycle 6; counter returns to 0.
- Same-rd under boost: reach BOOST, then present ex_rd = mem_rd = 6 -> mem granted first, ex next; write order on the port is mem data then ex data.
- x0 and mid-op reset: ex_rd = 0, data 0xFF -> ex_ready = 1, we = 0 next cycle. Assert rst while mem_valid is pending -> no grant; mem is granted on the first cycle after rst falls.
